branch_predict_controller: RTL and testbench

- Sequences control-flow redirection for the RV32IM 5-stage pipeline.
- In IF: direct-mapped branch target buffer (BTB) lookup with 2-bit counters supplies the predicted next PC.
- In EX: compares the branch unit's resolved outcome (BRANCH_SELECT / TARGET_ADDRESS) against the prediction carried down the pipe. On mismatch it issues the PC redirect and the IF/ID and ID/EX flushes, then trains the BTB.

---
 rtl/branch_predict_controller_pkg.sv | 31 +++
 rtl/branch_predict_controller_btb_table.sv | 75 +++++++
 rtl/branch_predict_controller.sv | 103 ++++++++++
 tb/tb_branch_predict_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_controller_pkg.sv
// Shared definitions for the branch predict controller: 2-bit counter
// encodings, the sequential-PC increment and BTB index/tag slicing helpers.
package branch_predict_controller_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr_e;

    localparam logic [31:0] PC_INC = 32'd4;

    // Callers narrow the results to their IDX_W / TAG_W with a size cast.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

    function automatic ctr_e ctr_inc(input ctr_e c);
        return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predict_controller_btb_table.sv
// Direct-mapped BTB storage: combinational IF read port and a synchronous
// training write port that performs the read-modify-write of the counter.
module branch_predict_controller_btb_table
    import branch_predict_controller_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int TAG_W  = 30 - IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_taken_o,
    output logic [31:0]      rd_target_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_taken_i,
    input  logic             wr_jump_i,
    input  logic [31:0]      wr_target_i
);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];

    logic wr_hit;
    ctr_e ctr_d;

    assign rd_taken_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i)
                         && (ctr_q[rd_idx_i] inside {WEAK_T, STRONG_T});
    assign rd_target_o = target_q[rd_idx_i];

    assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

    always_comb begin
        ctr_d = ctr_q[wr_idx_i];
        if (wr_taken_i) begin
            if (wr_jump_i) begin
                ctr_d = STRONG_T;
            end else if (wr_hit) begin
                ctr_d = ctr_inc(ctr_q[wr_idx_i]);
            end else begin
                ctr_d = WEAK_T;
            end
        end else begin
            ctr_d = ctr_dec(ctr_q[wr_idx_i]);
        end
    end

    // A taken resolve always (re)writes the whole entry; on a hit the tag and
    // valid bit are simply rewritten with their current values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= STRONG_NT;
            end
        end else if (wr_en_i) begin
            if (wr_taken_i) begin
                valid_q[wr_idx_i]  <= 1'b1;
                tag_q[wr_idx_i]    <= wr_tag_i;
                target_q[wr_idx_i] <= wr_target_i;
                ctr_q[wr_idx_i]    <= ctr_d;
            end else if (wr_hit) begin
                ctr_q[wr_idx_i]    <= ctr_d;
            end
        end
    end

endmodule

// File: rtl/branch_predict_controller.sv
// Control-flow redirection for the 5-stage pipeline: BTB prediction in IF,
// outcome check, redirect/flush and BTB training in EX, plus perf counters.
module branch_predict_controller
    import branch_predict_controller_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      IF_PC,
    output logic             IF_PRED_TAKEN,
    output logic [31:0]      IF_PRED_TARGET,
    input  logic             EX_VALID,
    input  logic             EX_IS_CTRL,
    input  logic             EX_IS_JUMP,
    input  logic [31:0]      EX_PC,
    input  logic             EX_PRED_TAKEN,
    input  logic [31:0]      EX_PRED_TARGET,
    input  logic             EX_BRANCH_SELECT,
    input  logic [31:0]      EX_TARGET_ADDRESS,
    input  logic             EX_HOLD,
    output logic             REDIRECT,
    output logic [31:0]      REDIRECT_PC,
    output logic             FLUSH_IFID,
    output logic             FLUSH_IDEX,
    output logic [CNT_W-1:0] CTRL_COUNT,
    output logic [CNT_W-1:0] MISPREDICT_COUNT
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             res, mis;
    logic [CNT_W-1:0] ctrl_count_q, ctrl_count_d;
    logic [CNT_W-1:0] mis_count_q, mis_count_d;

    assign if_idx = IDX_W'(pc_index(IF_PC, IDX_W));
    assign if_tag = TAG_W'(pc_tag(IF_PC, IDX_W));
    assign ex_idx = IDX_W'(pc_index(EX_PC, IDX_W));
    assign ex_tag = TAG_W'(pc_tag(EX_PC, IDX_W));

    branch_predict_controller_btb_table #(
        .ENTRIES (ENTRIES)
    ) u_btb (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .rd_idx_i    (if_idx),
        .rd_tag_i    (if_tag),
        .rd_taken_o  (pred_taken),
        .rd_target_o (pred_target),
        .wr_en_i     (res),
        .wr_idx_i    (ex_idx),
        .wr_tag_i    (ex_tag),
        .wr_taken_i  (EX_BRANCH_SELECT),
        .wr_jump_i   (EX_IS_JUMP),
        .wr_target_i (EX_TARGET_ADDRESS)
    );

    assign IF_PRED_TAKEN  = pred_taken;
    assign IF_PRED_TARGET = pred_taken ? pred_target : 32'd0;

    // A held instruction resolves only on the cycle it is released.
    assign res = EX_VALID && EX_IS_CTRL && !EX_HOLD;
    assign mis = res && !RESET
                 && ((EX_BRANCH_SELECT != EX_PRED_TAKEN)
                     || (EX_BRANCH_SELECT && (EX_TARGET_ADDRESS != EX_PRED_TARGET)));

    assign REDIRECT    = mis;
    assign FLUSH_IFID  = mis;
    assign FLUSH_IDEX  = mis;
    assign REDIRECT_PC = !mis            ? 32'd0 :
                         EX_BRANCH_SELECT ? EX_TARGET_ADDRESS : EX_PC + PC_INC;

    always_comb begin
        ctrl_count_d = ctrl_count_q;
        mis_count_d  = mis_count_q;
        if (res) begin
            ctrl_count_d = ctrl_count_q + CNT_W'(1);
        end
        if (mis) begin
            mis_count_d = mis_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl_count_q <= '0;
            mis_count_q  <= '0;
        end else begin
            ctrl_count_q <= ctrl_count_d;
            mis_count_q  <= mis_count_d;
        end
    end

    assign CTRL_COUNT       = ctrl_count_q;
    assign MISPREDICT_COUNT = mis_count_q;

endmodule

// File: tb/tb_branch_predict_controller.sv
// Bench for branch_predict_controller: hand-computed vector table, a
// mid-operation reset sequence and a model-checked random phase.
module tb_branch_predict_controller;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 32;
    localparam int W       = 256;

    logic        clk, rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_ctrl, ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_bsel;
    logic [31:0] ex_tgt;
    logic        ex_hold;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_ifid, flush_idex;
    logic [CNT_W-1:0] ctrl_count, mis_count;

    branch_predict_controller #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .CLK               (clk),
        .RESET             (rst),
        .IF_PC             (if_pc),
        .IF_PRED_TAKEN     (pred_taken),
        .IF_PRED_TARGET    (pred_target),
        .EX_VALID          (ex_valid),
        .EX_IS_CTRL        (ex_is_ctrl),
        .EX_IS_JUMP        (ex_is_jump),
        .EX_PC             (ex_pc),
        .EX_PRED_TAKEN     (ex_pred_taken),
        .EX_PRED_TARGET    (ex_pred_target),
        .EX_BRANCH_SELECT  (ex_bsel),
        .EX_TARGET_ADDRESS (ex_tgt),
        .EX_HOLD           (ex_hold),
        .REDIRECT          (redirect),
        .REDIRECT_PC       (redirect_pc),
        .FLUSH_IFID        (flush_ifid),
        .FLUSH_IDEX        (flush_idex),
        .CTRL_COUNT        (ctrl_count),
        .MISPREDICT_COUNT  (mis_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic [31:0] valid, ctrl, jump, pc, pt, ptgt, bsel, tgt, hold;
        logic [31:0] e_pt, e_ptgt, e_redir, e_rpc, e_ctrl, e_mis;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int step_no = 0;

    function automatic vec_t v(input logic [31:0] ipc, valid, ctrl, jump, pc, pt, ptgt,
                               bsel, tgt, hold, e_pt, e_ptgt, e_redir, e_rpc, e_ctrl, e_mis);
        vec_t r;
        r.if_pc = ipc;  r.valid = valid; r.ctrl = ctrl; r.jump = jump; r.pc = pc;
        r.pt = pt;      r.ptgt = ptgt;   r.bsel = bsel; r.tgt = tgt;   r.hold = hold;
        r.e_pt = e_pt;  r.e_ptgt = e_ptgt; r.e_redir = e_redir; r.e_rpc = e_rpc;
        r.e_ctrl = e_ctrl; r.e_mis = e_mis;
        return r;
    endfunction

    function automatic vec_t idle(input logic [31:0] ipc, e_pt, e_ptgt, e_ctrl, e_mis);
        return v(ipc, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_pt, e_ptgt, 0, 0, e_ctrl, e_mis);
    endfunction

    // driver tasks
    task automatic drive(input vec_t r);
        if_pc          = r.if_pc;
        ex_valid       = r.valid[0];
        ex_is_ctrl     = r.ctrl[0];
        ex_is_jump     = r.jump[0];
        ex_pc          = r.pc;
        ex_pred_taken  = r.pt[0];
        ex_pred_target = r.ptgt;
        ex_bsel        = r.bsel[0];
        ex_tgt         = r.tgt;
        ex_hold        = r.hold[0];
    endtask

    task automatic push_exp(input vec_t r);
        exp_q.push_back({r.e_pt, r.e_ptgt, r.e_redir, r.e_rpc,
                         r.e_redir, r.e_redir, r.e_ctrl, r.e_mis});
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    // scoreboard: pop one expected record and compare all outputs
    task automatic check_out();
        logic [W-1:0] e;
        logic [31:0] e_pt, e_ptgt, e_redir, e_rpc, e_fi, e_fx, e_ctrl, e_mis;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard step %0d: expected queue empty", step_no);
            return;
        end
        e = exp_q.pop_front();
        {e_pt, e_ptgt, e_redir, e_rpc, e_fi, e_fx, e_ctrl, e_mis} = e;
        cmp("pred_taken",  32'(pred_taken), e_pt);
        cmp("pred_target", pred_target,     e_ptgt);
        cmp("redirect",    32'(redirect),   e_redir);
        cmp("redirect_pc", redirect_pc,     e_rpc);
        cmp("flush_ifid",  32'(flush_ifid), e_fi);
        cmp("flush_idex",  32'(flush_idex), e_fx);
        cmp("ctrl_count",  ctrl_count,      e_ctrl);
        cmp("mis_count",   mis_count,       e_mis);
        step_no++;
    endtask

    task automatic apply_vec(input vec_t r);
        @(posedge clk);
        #1;
        drive(r);
        push_exp(r);
        @(negedge clk);
        check_out();
    endtask

    // reference model for the random phase
    logic        m_v   [ENTRIES];
    logic [31:0] m_tag [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    int          m_ctr [ENTRIES];
    logic [31:0] m_ctrl, m_mis;

    task automatic m_lookup(input logic [31:0] pc, output logic [31:0] t, output logic [31:0] g);
        int i;
        i = int'((pc >> 2) % ENTRIES);
        t = (m_v[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2) ? 1 : 0;
        g = t[0] ? m_tgt[i] : 32'd0;
    endtask

    task automatic m_update(input vec_t r);
        int i;
        logic hit;
        i = int'((r.pc >> 2) % ENTRIES);
        hit = m_v[i] && m_tag[i] == (r.pc >> 6);
        if (r.bsel[0]) begin
            if (hit) begin
                m_tgt[i] = r.tgt;
                m_ctr[i] = r.jump[0] ? 3 : (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1);
            end else begin
                m_v[i] = 1'b1;
                m_tag[i] = r.pc >> 6;
                m_tgt[i] = r.tgt;
                m_ctr[i] = r.jump[0] ? 3 : 2;
            end
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
    endtask

    logic [31:0] pc_pool  [6];
    logic [31:0] tgt_pool [4];

    initial begin
        vec_t r;
        logic [31:0] lt, lg;
        logic res, mis;

        pc_pool  = '{32'h100, 32'h140, 32'h104, 32'h200, 32'h3c4, 32'hfffffffc};
        tgt_pool = '{32'h80, 32'h300, 32'h340, 32'h500};

        rst = 1'b1;
        drive(idle(0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // fields: if_pc | valid ctrl jump pc pt ptgt bsel tgt hold | e_pt e_ptgt e_redir e_rpc e_ctrl e_mis
        vecs.push_back(idle('h100, 0, 0, 0, 0));
        vecs.push_back(v('h100, 1,1,0,'h100, 0,0,1,'h80,0, 0,0,1,'h80, 0,0));
        vecs.push_back(idle('h100, 1,'h80, 1,1));
        vecs.push_back(v('h100, 1,1,0,'h100, 1,'h80,0,0,0, 1,'h80,1,'h104, 1,1));
        vecs.push_back(idle('h100, 0,0, 2,2));
        vecs.push_back(v('h200, 1,1,0,'h100, 0,0,0,0,0, 0,0,0,0, 2,2));
        vecs.push_back(v('h200, 1,1,1,'h200, 0,0,1,'h300,0, 0,0,1,'h300, 3,2));
        vecs.push_back(idle('h200, 1,'h300, 4,3));
        vecs.push_back(v('h200, 1,1,1,'h200, 1,'h300,1,'h340,0, 1,'h300,1,'h340, 4,3));
        vecs.push_back(idle('h200, 1,'h340, 5,4));
        vecs.push_back(v('h100, 1,1,1,'h200, 1,'h340,1,'h340,0, 0,0,0,0, 5,4));
        for (int k = 0; k < 3; k++)
            vecs.push_back(v('h104, 1,1,0,'h104, 0,0,1,'h500,1, 0,0,0,0, 6,4));
        vecs.push_back(v('h104, 1,1,0,'h104, 0,0,1,'h500,0, 0,0,1,'h500, 6,4));
        vecs.push_back(idle('h104, 1,'h500, 7,5));
        vecs.push_back(v('h100, 1,1,0,'h100, 0,0,1,'h80,0, 0,0,1,'h80, 7,5));
        vecs.push_back(v('h140, 1,1,0,'h140, 0,0,1,'h180,0, 0,0,1,'h180, 8,6));
        vecs.push_back(idle('h140, 1,'h180, 9,7));
        vecs.push_back(idle('h100, 0,0, 9,7));
        vecs.push_back(v('h140, 1,1,0,'h140, 1,'h180,1,'h180,0, 1,'h180,0,0, 9,7));
        vecs.push_back(v('h140, 1,1,0,'h140, 1,'h180,0,0,0, 1,'h180,1,'h144, 10,7));
        vecs.push_back(idle('h140, 1,'h180, 11,8));
        vecs.push_back(v('h140, 1,0,0,'h140, 0,0,1,'h999,0, 1,'h180,0,0, 11,8));
        vecs.push_back(v('h140, 0,1,0,'h140, 0,0,1,'h999,0, 1,'h180,0,0, 11,8));
        vecs.push_back(v('hfffffffc, 1,1,0,'hfffffffc, 1,'h10,0,0,0, 0,0,1,0, 11,8));
        vecs.push_back(idle('hfffffffc, 0,0, 12,9));
        vecs.push_back(v('h104, 1,1,0,'h104, 1,'h500,0,0,0, 1,'h500,1,'h108, 12,9));
        vecs.push_back(v('h104, 1,1,0,'h104, 0,0,0,0,0, 0,0,0,0, 13,10));
        vecs.push_back(v('h104, 1,1,0,'h104, 0,0,1,'h500,0, 0,0,1,'h500, 14,10));
        vecs.push_back(idle('h104, 0,0, 15,11));

        foreach (vecs[k]) apply_vec(vecs[k]);

        // reset asserted while a mispredict sits in EX: all outputs clear at once
        @(posedge clk);
        #1;
        r = v('h140, 1,1,0,'h140, 1,'h180,0,0,0, 0,0,0,0, 0,0);
        drive(r);
        rst = 1'b1;
        push_exp(r);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
        drive(idle('h140, 0, 0, 0, 0));
        rst = 1'b0;
        apply_vec(idle('h140, 0, 0, 0, 0));

        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_ctrl = '0;
        m_mis  = '0;

        for (int n = 0; n < 400; n++) begin
            r.if_pc = pc_pool[$urandom_range(0, 5)];
            r.valid = ($urandom_range(0, 7) != 0) ? 1 : 0;
            r.ctrl  = ($urandom_range(0, 5) != 0) ? 1 : 0;
            r.jump  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r.pc    = pc_pool[$urandom_range(0, 5)];
            m_lookup(r.pc, lt, lg);
            if ($urandom_range(0, 3) != 0) begin
                r.pt = lt; r.ptgt = lg;
            end else begin
                r.pt = $urandom_range(0, 1); r.ptgt = tgt_pool[$urandom_range(0, 3)];
            end
            r.bsel = r.jump[0] ? 1 : $urandom_range(0, 1);
            r.tgt  = tgt_pool[$urandom_range(0, 3)];
            r.hold = ($urandom_range(0, 7) == 0) ? 1 : 0;
            m_lookup(r.if_pc, r.e_pt, r.e_ptgt);
            res = r.valid[0] && r.ctrl[0] && !r.hold[0];
            mis = res && ((r.bsel[0] != r.pt[0]) || (r.bsel[0] && r.tgt != r.ptgt));
            r.e_redir = mis ? 1 : 0;
            r.e_rpc   = !mis ? 32'd0 : (r.bsel[0] ? r.tgt : r.pc + 32'd4);
            r.e_ctrl  = m_ctrl;
            r.e_mis   = m_mis;
            apply_vec(r);
            if (res) begin
                m_update(r);
                m_ctrl = m_ctrl + 1;
            end
            if (mis) m_mis = m_mis + 1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
